int_ctrl: RTL and testbench

Memory-mapped interrupt controller between the system bridge and CP0 of the five-stage MIPS pipeline CPU. It registers up to six interrupt sources (Timer0, Timer1, external interrupt line, spares), applies per-source edge/level mode and a mask, and drives the HWInt vector into CP0. Handlers acknowledge interrupts by storing to the base address 0x7f20. Any store there clears pending requests, matching the external interrupt generator protocol used by the system-level bench.

---
 rtl/int_ctrl_pkg.sv | 30 +++
 rtl/int_ctrl_if.sv | 34 +++
 rtl/int_src_cell.sv | 45 ++++
 rtl/int_ctrl.sv | 111 +++++++++++
 tb/tb_int_ctrl.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/int_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : int_ctrl_pkg
//  Description : Shared constants and helpers for the int_ctrl interrupt
//                controller (register offsets, reset values, counter helper).
//  Revision    : 1.0 - initial release
// ============================================================================
package int_ctrl_pkg;

  localparam int N_SRC_DEF = 6;

  // Word offsets inside the 16-byte register window
  localparam logic [3:0] OFF_ACK   = 4'h0;
  localparam logic [3:0] OFF_MASK  = 4'h4;
  localparam logic [3:0] OFF_MODE  = 4'h8;
  localparam logic [3:0] OFF_COUNT = 4'hC;

  // Reset values, wide enough for any N_SRC; the top slices what it needs
  localparam logic [31:0] MASK_RST = 32'hffff_ffff;
  localparam logic [31:0] MODE_RST = 32'h0000_0000;

  localparam logic [15:0] COUNT_MAX = 16'hffff;

  // Saturating increment for the set-event counter
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == COUNT_MAX) ? v : v + 16'd1;
  endfunction

endpackage : int_ctrl_pkg
`default_nettype wire

// File: rtl/int_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : int_ctrl_if
//  Description : Bridge-side bus and interrupt signals of int_ctrl. The
//                master drives the bridge access and raw sources; the slave
//                (controller) returns read data, hit and the HWInt vector.
//  Revision    : 1.0 - initial release
// ============================================================================
interface int_ctrl_if
  import int_ctrl_pkg::*;
#(
  parameter int N_SRC = N_SRC_DEF
);

  logic [N_SRC-1:0] src_irq;
  logic [31:0]      addr;
  logic [31:0]      wdata;
  logic [3:0]       byteen;
  logic [31:0]      rdata;
  logic             hit;
  logic [N_SRC-1:0] hwint;

  modport master (
    output src_irq, addr, wdata, byteen,
    input  rdata, hit, hwint
  );

  modport slave (
    input  src_irq, addr, wdata, byteen,
    output rdata, hit, hwint
  );

endinterface : int_ctrl_if
`default_nettype wire

// File: rtl/int_src_cell.sv
`default_nettype none
// ============================================================================
//  Module      : int_src_cell
//  Description : One interrupt source: previous-sample flop, edge/level
//                select and a pending flop where a set beats a clear.
//                set_event flags a set that raises pending from 0 to 1.
//  Revision    : 1.0 - initial release
// ============================================================================
module int_src_cell
  import int_ctrl_pkg::*;
(
  input  wire logic clk,
  input  wire logic reset,
  input  wire logic src_irq,
  input  wire logic mode,       // 1 = edge, 0 = level
  input  wire logic clr,
  output logic      pending,
  output logic      set_event
);

  logic r_src_prev;
  logic r_pending;
  logic w_set;

  // Edge mode reacts only to a low-to-high transition; level mode follows the line
  always_comb begin
    w_set     = mode ? (src_irq & ~r_src_prev) : src_irq;
    set_event = w_set & ~r_pending;
  end

  // Source history and pending state; set has priority over clear
  always_ff @(posedge clk) begin
    if (reset) begin
      r_src_prev <= 1'b0;
      r_pending  <= 1'b0;
    end else begin
      r_src_prev <= src_irq;
      r_pending  <= w_set | (r_pending & ~clr);
    end
  end

  assign pending = r_pending;

endmodule : int_src_cell
`default_nettype wire

// File: rtl/int_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : int_ctrl
//  Description : Memory-mapped interrupt controller feeding CP0 HWInt.
//                Holds address decode, MASK/MODE/COUNT registers, the read
//                mux and one int_src_cell per source.
//  Revision    : 1.0 - initial release
// ============================================================================
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7f20,
  parameter int          N_SRC     = N_SRC_DEF
)(
  input  wire logic  clk,
  input  wire logic  reset,
  int_ctrl_if.slave  bus
);

  logic [N_SRC-1:0] r_mask;
  logic [N_SRC-1:0] r_mode;
  logic [15:0]      r_count;

  logic             w_hit;
  logic             w_store;
  logic [3:0]       w_off;
  logic             w_ack_wr;
  logic             w_mask_wr;
  logic             w_mode_wr;
  logic             w_count_wr;
  logic [N_SRC-1:0] w_clr;
  logic [N_SRC-1:0] w_pending;
  logic [N_SRC-1:0] w_set_event;
  logic [31:0]      w_rdata;

  // Byte lanes inside a word carry no meaning here; only the upper data bits
  // beyond the source count are ignored as well
  logic w_unused;
  assign w_unused = &{1'b0, bus.addr[1:0], bus.wdata[31:N_SRC]};

  // Address decode and write strobes; a zero ack mask means "clear everything"
  always_comb begin
    w_hit      = (bus.addr[31:4] == BASE_ADDR[31:4]);
    w_store    = w_hit & (|bus.byteen);
    w_off      = {bus.addr[3:2], 2'b00};
    w_ack_wr   = w_store & (w_off == OFF_ACK);
    w_mask_wr  = w_store & (w_off == OFF_MASK)  & bus.byteen[0];
    w_mode_wr  = w_store & (w_off == OFF_MODE)  & bus.byteen[0];
    w_count_wr = w_store & (w_off == OFF_COUNT);
    w_clr      = '0;
    if (w_ack_wr) begin
      w_clr = (bus.wdata[N_SRC-1:0] == '0) ? {N_SRC{1'b1}} : bus.wdata[N_SRC-1:0];
    end
  end

  generate
    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
      int_src_cell u_cell (
        .clk       (clk),
        .reset     (reset),
        .src_irq   (bus.src_irq[gi]),
        .mode      (r_mode[gi]),
        .clr       (w_clr[gi]),
        .pending   (w_pending[gi]),
        .set_event (w_set_event[gi])
      );
    end
  endgenerate

  // MASK and MODE registers, written from the low byte lane only
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mask <= MASK_RST[N_SRC-1:0];
      r_mode <= MODE_RST[N_SRC-1:0];
    end else begin
      if (w_mask_wr) r_mask <= bus.wdata[N_SRC-1:0];
      if (w_mode_wr) r_mode <= bus.wdata[N_SRC-1:0];
    end
  end

  // Saturating count of 0->1 pending transitions; a write clears and wins
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= 16'd0;
    end else if (w_count_wr) begin
      r_count <= 16'd0;
    end else if (|w_set_event) begin
      r_count <= sat_inc(r_count);
    end
  end

  // Combinational read mux, zero outside the window
  always_comb begin
    w_rdata = '0;
    if (w_hit) begin
      case (w_off)
        OFF_ACK:   w_rdata[N_SRC-1:0] = w_pending;
        OFF_MASK:  w_rdata[N_SRC-1:0] = r_mask;
        OFF_MODE:  w_rdata[N_SRC-1:0] = r_mode;
        OFF_COUNT: w_rdata[15:0]      = r_count;
        default:   w_rdata            = '0;
      endcase
    end
  end

  assign bus.rdata = w_rdata;
  assign bus.hit   = w_hit;
  assign bus.hwint = w_pending & r_mask;

endmodule : int_ctrl
`default_nettype wire

// File: tb/tb_int_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_int_ctrl
//  Description : Directed self-checking bench for int_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_int_ctrl;

  localparam logic [31:0] A_ACK   = 32'h0000_7f20;
  localparam logic [31:0] A_MASK  = 32'h0000_7f24;
  localparam logic [31:0] A_MODE  = 32'h0000_7f28;
  localparam logic [31:0] A_COUNT = 32'h0000_7f2c;
  localparam logic [31:0] A_MISS  = 32'h0000_7f30;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  int_ctrl_if #(.N_SRC(6)) bus ();

  int_ctrl #(.BASE_ADDR(32'h0000_7f20), .N_SRC(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.addr   = a;
    bus.wdata  = d;
    bus.byteen = be;
    step();
    bus.byteen = 4'b0000;
    bus.wdata  = 32'd0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    bus.addr = a;
    #1;
    d = bus.rdata;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    checks++; if (bus.hwint !== 6'b0) begin errors++; $display("FAIL reset_hwint got %h exp %h", bus.hwint, 6'b0); end
    rd(A_ACK, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_ack got %h exp %h", d, 32'h0); end
    checks++; if (bus.hit !== 1'b1) begin errors++; $display("FAIL reset_hit got %b exp 1", bus.hit); end
    rd(A_MASK, d);
    checks++; if (d !== 32'h3f) begin errors++; $display("FAIL reset_mask got %h exp %h", d, 32'h3f); end
    rd(A_MODE, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_mode got %h exp %h", d, 32'h0); end
    rd(A_COUNT, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_count got %h exp %h", d, 32'h0); end
  endtask

  task automatic test_level;
    logic [31:0] d;
    bus.src_irq = 6'b000100;
    step();
    checks++; if (bus.hwint !== 6'b000100) begin errors++; $display("FAIL level_first got %b exp %b", bus.hwint, 6'b000100); end
    step();
    step();
    checks++; if (bus.hwint !== 6'b000100) begin errors++; $display("FAIL level_hold got %b exp %b", bus.hwint, 6'b000100); end
    store(A_ACK, 32'd0, 4'b1111);
    checks++; if (bus.hwint !== 6'b000100) begin errors++; $display("FAIL level_ack_high got %b exp %b", bus.hwint, 6'b000100); end
    rd(A_COUNT, d);
    checks++; if (d !== 32'd1) begin errors++; $display("FAIL level_count got %h exp %h", d, 32'd1); end
    bus.src_irq = 6'b000000;
    step();
    store(A_ACK, 32'd0, 4'b1111);
    checks++; if (bus.hwint !== 6'b000000) begin errors++; $display("FAIL level_ack_low got %b exp %b", bus.hwint, 6'b0); end
  endtask

  task automatic test_edge;
    logic [31:0] d;
    store(A_MODE, 32'h03, 4'b1111);
    store(A_COUNT, 32'd0, 4'b1111);
    rd(A_MODE, d);
    checks++; if (d !== 32'h03) begin errors++; $display("FAIL edge_mode got %h exp %h", d, 32'h03); end
    bus.src_irq = 6'b000001;
    for (int i = 0; i < 10; i++) step();
    rd(A_ACK, d);
    checks++; if (d !== 32'h01) begin errors++; $display("FAIL edge_pending got %h exp %h", d, 32'h01); end
    rd(A_COUNT, d);
    checks++; if (d !== 32'd1) begin errors++; $display("FAIL edge_count got %h exp %h", d, 32'd1); end
    store(A_ACK, 32'd1, 4'b1111);
    step();
    step();
    rd(A_ACK, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL edge_no_reset got %h exp %h", d, 32'h0); end
    rd(A_COUNT, d);
    checks++; if (d !== 32'd1) begin errors++; $display("FAIL edge_count_after got %h exp %h", d, 32'd1); end
    bus.src_irq = 6'b000000;
    step();
  endtask

  task automatic test_mask;
    logic [31:0] d;
    bus.src_irq = 6'b000100;
    step();
    bus.src_irq = 6'b000000;
    store(A_MASK, 32'h3b, 4'b0001);
    checks++; if (bus.hwint !== 6'b000000) begin errors++; $display("FAIL mask_hw got %b exp %b", bus.hwint, 6'b0); end
    rd(A_ACK, d);
    checks++; if (d !== 32'h04) begin errors++; $display("FAIL mask_pending got %h exp %h", d, 32'h04); end
    store(A_MASK, 32'h3f, 4'b0001);
    checks++; if (bus.hwint !== 6'b000100) begin errors++; $display("FAIL mask_restore got %b exp %b", bus.hwint, 6'b000100); end
    store(A_ACK, 32'd0, 4'b1111);
    checks++; if (bus.hwint !== 6'b000000) begin errors++; $display("FAIL mask_ack got %b exp %b", bus.hwint, 6'b0); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] d;
    // rising edge on bit 0 in the same cycle as an ack of bit 0
    bus.src_irq = 6'b000001;
    store(A_ACK, 32'd1, 4'b1111);
    rd(A_ACK, d);
    checks++; if (d !== 32'h01) begin errors++; $display("FAIL set_over_clr got %h exp %h", d, 32'h01); end
    store(A_ACK, 32'd1, 4'b1111);
    bus.src_irq = 6'b000010;
    step();
    bus.src_irq = 6'b000000;
    store(A_ACK, 32'd0, 4'b0000);
    rd(A_ACK, d);
    checks++; if (d !== 32'h02) begin errors++; $display("FAIL no_byteen got %h exp %h", d, 32'h02); end
    store(A_MISS, 32'd0, 4'b1111);
    bus.addr = A_MISS;
    #1;
    checks++; if (bus.hit !== 1'b0) begin errors++; $display("FAIL miss_hit got %b exp 0", bus.hit); end
    checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL miss_rdata got %h exp %h", bus.rdata, 32'h0); end
    rd(A_ACK, d);
    checks++; if (d !== 32'h02) begin errors++; $display("FAIL miss_store got %h exp %h", d, 32'h02); end
    store(A_ACK, 32'd0, 4'b1111);
  endtask

  task automatic test_count_sat;
    logic [31:0] d;
    logic [31:0] exp;
    store(A_COUNT, 32'd0, 4'b1111);
    // alternate edge sources while acking every cycle: one new event per cycle
    for (int i = 0; i < 65536; i++) begin
      bus.src_irq = i[0] ? 6'b000010 : 6'b000001;
      bus.addr    = A_ACK;
      bus.wdata   = 32'd0;
      bus.byteen  = 4'b1111;
      step();
      if (i == 65533 || i == 65534 || i == 65535) begin
        bus.byteen = 4'b0000;
        rd(A_COUNT, d);
        exp = (i == 65533) ? 32'h0000_fffe : 32'h0000_ffff;
        checks++; if (d !== exp) begin errors++; $display("FAIL count_sat_%0d got %h exp %h", i, d, exp); end
      end
    end
    bus.byteen  = 4'b0000;
    bus.src_irq = 6'b000000;
    store(A_COUNT, 32'd0, 4'b1111);
    rd(A_COUNT, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL count_clear got %h exp %h", d, 32'h0); end
    store(A_ACK, 32'd0, 4'b1111);
  endtask

  task automatic test_reset_mid;
    logic [31:0] d;
    store(A_MASK, 32'h00, 4'b1111);
    store(A_MODE, 32'h2a, 4'b1111);
    bus.src_irq = 6'b111111;
    step();
    rd(A_ACK, d);
    checks++; if (d !== 32'h3f) begin errors++; $display("FAIL mid_pending got %h exp %h", d, 32'h3f); end
    reset = 1'b1;
    store(A_ACK, 32'h3f, 4'b1111);
    checks++; if (bus.hwint !== 6'b000000) begin errors++; $display("FAIL mid_hwint got %b exp %b", bus.hwint, 6'b0); end
    rd(A_ACK, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL mid_ack got %h exp %h", d, 32'h0); end
    rd(A_MASK, d);
    checks++; if (d !== 32'h3f) begin errors++; $display("FAIL mid_mask got %h exp %h", d, 32'h3f); end
    rd(A_MODE, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL mid_mode got %h exp %h", d, 32'h0); end
    rd(A_COUNT, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL mid_count got %h exp %h", d, 32'h0); end
    bus.src_irq = 6'b000000;
    reset = 1'b0;
    step();
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    reset       = 1'b1;
    bus.src_irq = '0;
    bus.addr    = 32'd0;
    bus.wdata   = 32'd0;
    bus.byteen  = 4'b0000;
    test_reset();
    test_level();
    test_edge();
    test_mask();
    test_back_to_back();
    test_count_sat();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_int_ctrl
`default_nettype wire
